// File: rtl/infernet_net_pkg.sv
// Shared Ethernet/IPv4 constants and parser state type.
// Imported by both the RX parser and the TX packetiser.
package infernet_net_pkg;

    localparam int ETH_HDR_SIZE_BYTES = 14;
    localparam int IP_HDR_SIZE_BYTES  = 20;
    localparam int RX_CNT_WIDTH       = 8;

    localparam logic [15:0] ETH_TYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IP_VERSION_IHL = 8'h45;
    localparam logic [47:0] BROADCAST_MAC  = 48'hffff_ffff_ffff;

    typedef enum logic [2:0] {
        RX_ETH_HDR,
        RX_IP_HDR,
        RX_PAYLOAD,
        DRAIN,
        HOLD
    } rx_state_e;

    // Addresses are little-endian: wire byte i lives in bits [8i+7:8i].
    function automatic logic [7:0] addr_byte(input logic [47:0] addr,
                                             input logic [2:0]  idx);
        return addr[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/counter_sync_reset.sv
// Saturating up-counter with synchronous clear and enable.
// Saturation keeps long frames from wrapping back into capture windows.
module counter_sync_reset #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en && !(&count_q)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ip_packet_rx.sv
// Ethernet/IPv4 receive parser: filters frames for this accelerator and
// extracts sender addresses plus the leading payload bytes.
module ip_packet_rx
    import infernet_net_pkg::*;
#(
    parameter int PAYLOAD_BYTES    = 2,
    parameter int ACCEPT_BROADCAST = 1,
    parameter int DROP_CNT_WIDTH   = 16
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [31:0]                 ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                 ACCELERATOR_MAC_ADDRESS,
    input  logic [7:0]                  MAC_DATA_IN,
    input  logic                        MAC_DATA_VALID,
    input  logic                        MAC_DATA_LAST,
    input  logic                        MAC_DATA_TUSER,
    output logic                        MAC_DATA_READY,
    output logic [47:0]                 SENDER_MAC_ADDRESS,
    output logic [31:0]                 SENDER_IP_ADDRESS,
    output logic [8*PAYLOAD_BYTES-1:0]  PAYLOAD_DATA,
    output logic                        PAYLOAD_VALID,
    input  logic                        PAYLOAD_READY,
    output logic [DROP_CNT_WIDTH-1:0]   DROP_COUNT
);

    rx_state_e state_q, state_d, hdr_next;

    logic [RX_CNT_WIDTH-1:0]     cnt_q;
    logic [47:0]                 smac_q, smac_d;
    logic [31:0]                 sip_q, sip_d;
    logic [8*PAYLOAD_BYTES-1:0]  pay_q, pay_d;
    logic [DROP_CNT_WIDTH-1:0]   drop_q, drop_d;
    logic                        dm_own_q, dm_own_d;
    logic                        dm_bc_q, dm_bc_d;

    logic beat, bad, done, full, accept, own_hit, bc_hit;

    assign MAC_DATA_READY = (state_q != HOLD);
    assign beat           = MAC_DATA_VALID & MAC_DATA_READY;

    counter_sync_reset #(
        .WIDTH (RX_CNT_WIDTH)
    ) u_byte_cnt (
        .clk   (ACLK),
        .rst_n (ARESET),
        .clear (state_d != state_q),
        .en    (beat),
        .count (cnt_q)
    );

    always_comb begin
        state_d  = state_q;
        hdr_next = RX_ETH_HDR;
        smac_d   = smac_q;
        sip_d    = sip_q;
        pay_d    = pay_q;
        drop_d   = drop_q;
        dm_own_d = dm_own_q;
        dm_bc_d  = dm_bc_q;
        bad      = 1'b0;
        done     = 1'b0;
        own_hit  = 1'b0;
        bc_hit   = 1'b0;
        full     = cnt_q >= RX_CNT_WIDTH'(PAYLOAD_BYTES - 1);
        accept   = full & ~MAC_DATA_TUSER;

        if (beat) begin
            unique case (state_q)
                RX_ETH_HDR: begin
                    hdr_next = RX_IP_HDR;
                    if (cnt_q < 8'd6) begin
                        // Dest must be entirely own MAC or entirely broadcast.
                        own_hit = (cnt_q == 8'd0 || dm_own_q) &&
                            MAC_DATA_IN == addr_byte(ACCELERATOR_MAC_ADDRESS, cnt_q[2:0]);
                        bc_hit = (ACCEPT_BROADCAST != 0) &&
                            (cnt_q == 8'd0 || dm_bc_q) &&
                            MAC_DATA_IN == addr_byte(BROADCAST_MAC, cnt_q[2:0]);
                        dm_own_d = own_hit;
                        dm_bc_d  = bc_hit;
                        bad      = !(own_hit || bc_hit);
                    end else if (cnt_q < 8'd12) begin
                        for (int i = 0; i < 6; i++) begin
                            if (cnt_q == 8'(6 + i)) smac_d[i*8 +: 8] = MAC_DATA_IN;
                        end
                    end else if (cnt_q == 8'd12) begin
                        bad = MAC_DATA_IN != ETH_TYPE_IPV4[15:8];
                    end else begin
                        bad  = MAC_DATA_IN != ETH_TYPE_IPV4[7:0];
                        done = 1'b1;
                    end
                end
                RX_IP_HDR: begin
                    hdr_next = RX_PAYLOAD;
                    if (cnt_q == 8'd0) bad = MAC_DATA_IN != IP_VERSION_IHL;
                    for (int i = 0; i < 4; i++) begin
                        if (cnt_q == 8'(12 + i)) sip_d[i*8 +: 8] = MAC_DATA_IN;
                    end
                    // Bytes 16..19 map onto address bytes 0..3 via cnt[2:0].
                    if (cnt_q >= 8'd16) begin
                        bad = MAC_DATA_IN !=
                            addr_byte({16'h0, ACCELERATOR_IP_ADDRESS}, cnt_q[2:0]);
                    end
                    done = cnt_q == 8'(IP_HDR_SIZE_BYTES - 1);
                end
                RX_PAYLOAD: begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (cnt_q == 8'(i)) begin
                            pay_d[(PAYLOAD_BYTES-1-i)*8 +: 8] = MAC_DATA_IN;
                        end
                    end
                end
                default: ;
            endcase

            if (state_q == RX_PAYLOAD && MAC_DATA_LAST && accept) begin
                state_d = HOLD;
            end else if (MAC_DATA_LAST) begin
                state_d = RX_ETH_HDR;
                drop_d  = (&drop_q) ? drop_q : drop_q + DROP_CNT_WIDTH'(1);
            end else if (bad) begin
                state_d = DRAIN;
            end else if (done) begin
                state_d = hdr_next;
            end
        end else if (state_q == HOLD && PAYLOAD_READY) begin
            state_d = RX_ETH_HDR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q  <= RX_ETH_HDR;
            smac_q   <= '0;
            sip_q    <= '0;
            pay_q    <= '0;
            drop_q   <= '0;
            dm_own_q <= 1'b0;
            dm_bc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            smac_q   <= smac_d;
            sip_q    <= sip_d;
            pay_q    <= pay_d;
            drop_q   <= drop_d;
            dm_own_q <= dm_own_d;
            dm_bc_q  <= dm_bc_d;
        end
    end

    assign SENDER_MAC_ADDRESS = smac_q;
    assign SENDER_IP_ADDRESS  = sip_q;
    assign PAYLOAD_DATA       = pay_q;
    assign PAYLOAD_VALID      = (state_q == HOLD);
    assign DROP_COUNT         = drop_q;

endmodule

// File: tb/tb_ip_packet_rx.sv
// Directed bench for ip_packet_rx: filtering, capture, hold/back-pressure,
// error drops and drop-counter saturation (3-bit counter instance).
module tb_ip_packet_rx;

    localparam logic [47:0] OWN_MAC = 48'h665544332211;
    localparam logic [31:0] OWN_IP  = 32'h0A00A8C0;
    localparam logic [47:0] EXP_SMAC = 48'hCCBBAA000002;
    localparam logic [31:0] EXP_SIP  = 32'h0100000A;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  MAC_DATA_IN;
    logic        MAC_DATA_VALID;
    logic        MAC_DATA_LAST;
    logic        MAC_DATA_TUSER;
    logic        MAC_DATA_READY;
    logic [47:0] SENDER_MAC_ADDRESS;
    logic [31:0] SENDER_IP_ADDRESS;
    logic [15:0] PAYLOAD_DATA;
    logic        PAYLOAD_VALID;
    logic        PAYLOAD_READY;
    logic [2:0]  DROP_COUNT;

    int passed = 0;
    int total  = 0;
    int stalls = 0;
    logic [7:0] frame_q[$];

    ip_packet_rx #(
        .PAYLOAD_BYTES    (2),
        .ACCEPT_BROADCAST (1),
        .DROP_CNT_WIDTH   (3)
    ) dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (OWN_IP),
        .ACCELERATOR_MAC_ADDRESS (OWN_MAC),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .SENDER_MAC_ADDRESS      (SENDER_MAC_ADDRESS),
        .SENDER_IP_ADDRESS       (SENDER_IP_ADDRESS),
        .PAYLOAD_DATA            (PAYLOAD_DATA),
        .PAYLOAD_VALID           (PAYLOAD_VALID),
        .PAYLOAD_READY           (PAYLOAD_READY),
        .DROP_COUNT              (DROP_COUNT)
    );

    always #5 ACLK = ~ACLK;

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] et,
                               input logic [7:0] vihl, input logic [31:0] dip,
                               input logic [15:0] pay, input int len);
        logic [7:0] src_mac[6];
        logic [7:0] src_ip[4];
        src_mac = '{8'h02, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        src_ip  = '{8'h0A, 8'h00, 8'h00, 8'h01};
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back(dmac[i*8 +: 8]);
        for (int i = 0; i < 6; i++) frame_q.push_back(src_mac[i]);
        frame_q.push_back(et[15:8]);
        frame_q.push_back(et[7:0]);
        frame_q.push_back(vihl);
        for (int i = 0; i < 11; i++) frame_q.push_back(8'h00);
        for (int i = 0; i < 4; i++) frame_q.push_back(src_ip[i]);
        for (int i = 0; i < 4; i++) frame_q.push_back(dip[i*8 +: 8]);
        frame_q.push_back(pay[15:8]);
        frame_q.push_back(pay[7:0]);
        while (frame_q.size() < len) frame_q.push_back(8'h5A);
    endtask

    // Starts and ends on a falling edge; one byte per cycle when ready.
    task automatic send_frame(input int n, input logic tuser, input logic with_last);
        int guard;
        for (int i = 0; i < n; i++) begin
            MAC_DATA_IN    = frame_q[i];
            MAC_DATA_VALID = 1'b1;
            MAC_DATA_LAST  = with_last && (i == n - 1);
            MAC_DATA_TUSER = tuser && (i == n - 1);
            guard = 0;
            while (!MAC_DATA_READY && guard < 50) begin
                stalls++;
                guard++;
                @(negedge ACLK);
            end
            if (guard >= 50) begin
                total++;
                $display("FAIL send_timeout: ready=%0b required 1", MAC_DATA_READY);
            end
            @(posedge ACLK);
            @(negedge ACLK);
        end
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
    endtask

    task automatic release_payload();
        PAYLOAD_READY = 1'b1;
        @(posedge ACLK);
        @(negedge ACLK);
        PAYLOAD_READY = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (MAC_DATA_READY !== 1'b1) $display("FAIL rst_ready: got %b required 1", MAC_DATA_READY);
        else passed++;
        total++;
        if (PAYLOAD_VALID !== 1'b0) $display("FAIL rst_pvalid: got %b required 0", PAYLOAD_VALID);
        else passed++;
        total++;
        if (DROP_COUNT !== 3'd0) $display("FAIL rst_drop: got %0d required 0", DROP_COUNT);
        else passed++;
        total++;
        if ({SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS, PAYLOAD_DATA} !== 96'h0)
            $display("FAIL rst_capture: got %h %h %h required 0",
                     SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS, PAYLOAD_DATA);
        else passed++;
    endtask

    task automatic test_valid_frame();
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h02A5, 40);
        send_frame(40, 1'b0, 1'b1);
        total++;
        if (PAYLOAD_VALID !== 1'b1) $display("FAIL valid_pvalid: got %b required 1", PAYLOAD_VALID);
        else passed++;
        total++;
        if (PAYLOAD_DATA !== 16'h02A5) $display("FAIL valid_payload: got %h required 02a5", PAYLOAD_DATA);
        else passed++;
        total++;
        if (SENDER_MAC_ADDRESS !== EXP_SMAC)
            $display("FAIL valid_smac: got %h required %h", SENDER_MAC_ADDRESS, EXP_SMAC);
        else passed++;
        total++;
        if (SENDER_IP_ADDRESS !== EXP_SIP)
            $display("FAIL valid_sip: got %h required %h", SENDER_IP_ADDRESS, EXP_SIP);
        else passed++;
        total++;
        if ({MAC_DATA_READY, DROP_COUNT} !== {1'b0, 3'd0})
            $display("FAIL valid_ready_drop: got %b/%0d required 0/0", MAC_DATA_READY, DROP_COUNT);
        else passed++;
        release_payload();
        total++;
        if ({PAYLOAD_VALID, MAC_DATA_READY} !== 2'b01)
            $display("FAIL valid_release: got pv=%b rdy=%b required 0/1", PAYLOAD_VALID, MAC_DATA_READY);
        else passed++;
    endtask

    task automatic test_bad_dmac();
        build_frame(48'h665599332211, 16'h0800, 8'h45, OWN_IP, 16'h1234, 60);
        stalls = 0;
        send_frame(60, 1'b0, 1'b1);
        total++;
        if (stalls !== 0) $display("FAIL dmac_ready: got %0d stalls required 0", stalls);
        else passed++;
        total++;
        if ({PAYLOAD_VALID, DROP_COUNT} !== {1'b0, 3'd1})
            $display("FAIL dmac_drop: got pv=%b drop=%0d required 0/1", PAYLOAD_VALID, DROP_COUNT);
        else passed++;
    endtask

    task automatic test_filters();
        build_frame(OWN_MAC, 16'h86DD, 8'h45, OWN_IP, 16'h1111, 40);
        send_frame(40, 1'b0, 1'b1);
        build_frame(OWN_MAC, 16'h0800, 8'h46, OWN_IP, 16'h2222, 40);
        send_frame(40, 1'b0, 1'b1);
        build_frame(OWN_MAC, 16'h0800, 8'h45, 32'h0B00A8C0, 16'h3333, 40);
        send_frame(40, 1'b0, 1'b1);
        total++;
        if ({PAYLOAD_VALID, DROP_COUNT} !== {1'b0, 3'd4})
            $display("FAIL filter_drop: got pv=%b drop=%0d required 0/4", PAYLOAD_VALID, DROP_COUNT);
        else passed++;
        build_frame(48'hFFFFFFFFFFFF, 16'h0800, 8'h45, OWN_IP, 16'hBCDE, 36);
        send_frame(36, 1'b0, 1'b1);
        total++;
        if ({PAYLOAD_VALID, PAYLOAD_DATA, DROP_COUNT} !== {1'b1, 16'hBCDE, 3'd4})
            $display("FAIL filter_bcast: got pv=%b data=%h drop=%0d required 1/bcde/4",
                     PAYLOAD_VALID, PAYLOAD_DATA, DROP_COUNT);
        else passed++;
        release_payload();
    endtask

    task automatic test_back_to_back();
        int bad_cycles;
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h1122, 40);
        send_frame(40, 1'b0, 1'b1);
        bad_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            if ({MAC_DATA_READY, PAYLOAD_VALID, PAYLOAD_DATA, SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS}
                !== {1'b0, 1'b1, 16'h1122, EXP_SMAC, EXP_SIP}) bad_cycles++;
            @(negedge ACLK);
        end
        total++;
        if (bad_cycles !== 0) $display("FAIL hold_stable: got %0d bad cycles required 0", bad_cycles);
        else passed++;
        release_payload();
        total++;
        if ({MAC_DATA_READY, PAYLOAD_VALID} !== 2'b10)
            $display("FAIL hold_release: got rdy=%b pv=%b required 1/0", MAC_DATA_READY, PAYLOAD_VALID);
        else passed++;
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h3344, 36);
        send_frame(36, 1'b0, 1'b1);
        total++;
        if ({PAYLOAD_VALID, PAYLOAD_DATA} !== {1'b1, 16'h3344})
            $display("FAIL b2b_second: got pv=%b data=%h required 1/3344", PAYLOAD_VALID, PAYLOAD_DATA);
        else passed++;
        release_payload();
    endtask

    task automatic test_errors();
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h5555, 40);
        send_frame(10, 1'b0, 1'b1);
        total++;
        if ({PAYLOAD_VALID, DROP_COUNT} !== {1'b0, 3'd5})
            $display("FAIL short_drop: got pv=%b drop=%0d required 0/5", PAYLOAD_VALID, DROP_COUNT);
        else passed++;
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h6666, 40);
        send_frame(40, 1'b1, 1'b1);
        total++;
        if ({PAYLOAD_VALID, DROP_COUNT} !== {1'b0, 3'd6})
            $display("FAIL tuser_drop: got pv=%b drop=%0d required 0/6", PAYLOAD_VALID, DROP_COUNT);
        else passed++;
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h7788, 38);
        send_frame(38, 1'b0, 1'b1);
        total++;
        if ({PAYLOAD_VALID, PAYLOAD_DATA, DROP_COUNT} !== {1'b1, 16'h7788, 3'd6})
            $display("FAIL after_err: got pv=%b data=%h drop=%0d required 1/7788/6",
                     PAYLOAD_VALID, PAYLOAD_DATA, DROP_COUNT);
        else passed++;
        release_payload();
    endtask

    task automatic test_async_reset();
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'h9999, 40);
        send_frame(20, 1'b0, 1'b0);
        #2 ARESET = 1'b0;
        #1;
        total++;
        if ({MAC_DATA_READY, PAYLOAD_VALID, DROP_COUNT} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL areset_ctl: got rdy=%b pv=%b drop=%0d required 1/0/0",
                     MAC_DATA_READY, PAYLOAD_VALID, DROP_COUNT);
        else passed++;
        total++;
        if ({SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS, PAYLOAD_DATA} !== 96'h0)
            $display("FAIL areset_capture: got %h %h %h required 0",
                     SENDER_MAC_ADDRESS, SENDER_IP_ADDRESS, PAYLOAD_DATA);
        else passed++;
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        build_frame(OWN_MAC, 16'h0800, 8'h45, OWN_IP, 16'hC33C, 36);
        send_frame(36, 1'b0, 1'b1);
        total++;
        if ({PAYLOAD_VALID, PAYLOAD_DATA, SENDER_IP_ADDRESS, DROP_COUNT} !== {1'b1, 16'hC33C, EXP_SIP, 3'd0})
            $display("FAIL areset_next: got pv=%b data=%h sip=%h drop=%0d required 1/c33c/%h/0",
                     PAYLOAD_VALID, PAYLOAD_DATA, SENDER_IP_ADDRESS, DROP_COUNT, EXP_SIP);
        else passed++;
        release_payload();
        frame_q.delete();
        frame_q.push_back(8'h11);
        for (int k = 0; k < 7; k++) send_frame(1, 1'b0, 1'b1);
        total++;
        if (DROP_COUNT !== 3'd7) $display("FAIL drop_full: got %0d required 7", DROP_COUNT);
        else passed++;
        send_frame(1, 1'b0, 1'b1);
        total++;
        if (DROP_COUNT !== 3'd7) $display("FAIL drop_saturate: got %0d required 7", DROP_COUNT);
        else passed++;
    endtask

    initial begin
        ARESET         = 1'b0;
        MAC_DATA_IN    = 8'h00;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_LAST  = 1'b0;
        MAC_DATA_TUSER = 1'b0;
        PAYLOAD_READY  = 1'b0;
        repeat (2) @(negedge ACLK);
        test_reset();
        @(negedge ACLK);
        ARESET = 1'b1;
        @(negedge ACLK);
        test_valid_frame();
        test_bad_dmac();
        test_filters();
        test_back_to_back();
        test_errors();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
